blob_metrics: RTL and testbench

BLOB_METRICS -- requirements
Module: blob_metrics

---
 rtl/blob_metrics.sv | 130 +++++++++++++
 tb/tb_blob_metrics.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/blob_metrics.sv
// Blob area and crack-edge perimeter over one raster-scanned mask frame.
// Results are held while the downstream stage is busy.
module blob_metrics #(
    parameter int WIDTH  = 180,
    parameter int HEIGHT = 320,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH*HEIGHT) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [XW-1:0] hcount_in,
    input  logic [YW-1:0] vcount_in,
    input  logic          mask_in,
    input  logic          data_valid_in,
    input  logic          busy_in,
    output logic [AW-1:0] area_out,
    output logic [AW-1:0] perimeter_out,
    output logic          valid_out,
    output logic          busy_out,
    output logic          overrun_out
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    state_t          state_q;
    logic [AW-1:0]   area_q, area_d;
    logic [AW-1:0]   perim_q, perim_d;
    logic [AW-1:0]   area_out_q, perim_out_q;
    logic            valid_q, ovr_q;
    logic            act_q, pend_q;
    logic            prev_q;
    logic [WIDTH-1:0] lb_q;

    logic       accepted, start, done;
    logic       left_m, up_m;
    logic [2:0] inc;

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                              input logic [2:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {{(AW-2){1'b0}}, b};
        return s[AW] ? '1 : s[AW-1:0];
    endfunction

    assign accepted = data_valid_in && (hcount_in <= XMAX) && (vcount_in <= YMAX);
    assign start    = accepted && (hcount_in == '0) && (vcount_in == '0);
    // A frame completes only if its (0,0) was seen; with a 1x1 frame both coincide.
    assign done     = accepted && (hcount_in == XMAX) && (vcount_in == YMAX)
                      && (act_q || start);

    // Per-pixel perimeter contribution from left, top, right and bottom cracks.
    always_comb begin
        left_m  = (hcount_in == '0) ? 1'b0 : prev_q;
        up_m    = (vcount_in == '0) ? 1'b0 : lb_q[hcount_in];
        inc     = {2'b00, mask_in ^ left_m}
                + {2'b00, mask_in ^ up_m}
                + {2'b00, mask_in && (hcount_in == XMAX)}
                + {2'b00, mask_in && (vcount_in == YMAX)};
        area_d  = sat_add(start ? '0 : area_q, {2'b00, mask_in});
        perim_d = sat_add(start ? '0 : perim_q, inc);
    end

    // Frame accumulation, line buffer and result-delivery state machine.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            area_q      <= '0;
            perim_q     <= '0;
            area_out_q  <= '0;
            perim_out_q <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            act_q       <= 1'b0;
            pend_q      <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            if (accepted) begin
                area_q           <= area_d;
                perim_q          <= perim_d;
                prev_q           <= mask_in;
                lb_q[hcount_in]  <= mask_in;
            end
            if (start) act_q <= 1'b1;
            if (done)  act_q <= 1'b0;
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (done)       state_q <= FLUSH;
                    else if (start) state_q <= ACCUM;
                end
                FLUSH: begin
                    area_out_q  <= area_q;
                    perim_out_q <= perim_q;
                    if (!busy_in) valid_q <= 1'b1;
                    if (done)              state_q <= FLUSH;
                    else if (busy_in)      state_q <= HOLD;
                    else if (act_q || start) state_q <= ACCUM;
                    else                   state_q <= IDLE;
                end
                HOLD: begin
                    if (pend_q) begin
                        area_out_q  <= area_q;
                        perim_out_q <= perim_q;
                        ovr_q       <= 1'b1;
                        pend_q      <= 1'b0;
                    end else if (!busy_in) begin
                        valid_q <= 1'b1;
                        if (done)                state_q <= FLUSH;
                        else if (act_q || start) state_q <= ACCUM;
                        else                     state_q <= IDLE;
                    end else if (done) begin
                        pend_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign area_out      = area_out_q;
    assign perimeter_out = perim_out_q;
    assign valid_out     = valid_q;
    assign overrun_out   = ovr_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_blob_metrics.sv
// Directed bench for blob_metrics on an 8x6 frame.
// Frame vectors are table-driven; hold, overrun and reset are hand sequences.
module tb_blob_metrics;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    hc = '0;
    logic [2:0]    vc = '0;
    logic          m = 1'b0;
    logic          dv = 1'b0;
    logic          bsy = 1'b0;
    logic [AW-1:0] area, perim;
    logic          vld, busy_o, ovr;

    int n_chk = 0;
    int n_fail = 0;
    int vcnt = 0;
    int ocnt = 0;
    int cap_a = 0;
    int cap_p = 0;

    blob_metrics #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hc), .vcount_in(vc),
        .mask_in(m), .data_valid_in(dv), .busy_in(bsy),
        .area_out(area), .perimeter_out(perim),
        .valid_out(vld), .busy_out(busy_o), .overrun_out(ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vld) begin
            vcnt  <= vcnt + 1;
            cap_a <= int'(area);
            cap_p <= int'(perim);
        end
        if (ovr) ocnt <= ocnt + 1;
    end

    typedef struct {
        string       name;
        logic [47:0] pat;
        int          area;
        int          perim;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_pixels(input logic [47:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            dv = 1'b1;
            hc = 3'(i % W);
            vc = 3'(i / W);
            m  = pat[i];
        end
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        dv = 1'b0;
        m  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] rect;
        int v0, o0;

        rect = '0;
        for (int y = 1; y <= 3; y++)
            for (int x = 2; x <= 3; x++)
                rect[y*W + x] = 1'b1;

        vecs[0] = '{"zero",   48'h0,          0,  0};
        vecs[1] = '{"pix32",  48'h1 << 19,    1,  4};
        vecs[2] = '{"pix00",  48'h1,          1,  4};
        vecs[3] = '{"full",   {48{1'b1}},    48, 28};
        vecs[4] = '{"rect",   rect,           6, 10};

        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_area",  int'(area),   0);
        chk("rst_perim", int'(perim),  0);
        chk("rst_valid", int'(vld),    0);
        chk("rst_busy",  int'(busy_o), 0);
        chk("rst_ovr",   int'(ovr),    0);

        // Out-of-range row is not a frame start.
        @(posedge clk); #1;
        dv = 1'b1; hc = 3'd0; vc = 3'd7; m = 1'b1;
        end_frame();
        @(negedge clk);
        chk("oob_busy", int'(busy_o), 0);

        for (int k = 0; k < 5; k++) begin
            send_pixels(vecs[k].pat, N);
            end_frame();
            @(negedge clk);
            chk({vecs[k].name, "_flush_v"}, int'(vld), 0);
            chk({vecs[k].name, "_flush_b"}, int'(busy_o), 1);
            @(negedge clk);
            chk({vecs[k].name, "_valid"}, int'(vld), 1);
            chk({vecs[k].name, "_area"},  int'(area),  vecs[k].area);
            chk({vecs[k].name, "_perim"}, int'(perim), vecs[k].perim);
            @(negedge clk);
            chk({vecs[k].name, "_pulse"}, int'(vld), 0);
            chk({vecs[k].name, "_idle"},  int'(busy_o), 0);
        end

        // Downstream busy for 5 cycles after frame end.
        bsy = 1'b1;
        send_pixels(vecs[3].pat, N);
        end_frame();
        v0 = vcnt;
        wait_cycles(5);
        @(negedge clk);
        chk("hold_novalid", vcnt - v0, 0);
        chk("hold_busy",    int'(busy_o), 1);
        chk("hold_area",    int'(area), 48);
        chk("hold_perim",   int'(perim), 28);
        @(posedge clk); #1;
        bsy = 1'b0;
        wait_cycles(4);
        @(negedge clk);
        chk("hold_vcnt",  vcnt - v0, 1);
        chk("hold_cap_a", cap_a, 48);
        chk("hold_cap_p", cap_p, 28);
        chk("hold_idle",  int'(busy_o), 0);

        // Second frame finishes while the first is still held.
        bsy = 1'b1;
        v0 = vcnt;
        o0 = ocnt;
        send_pixels(vecs[4].pat, N);
        end_frame();
        wait_cycles(2);
        send_pixels(vecs[1].pat, N);
        end_frame();
        wait_cycles(4);
        @(negedge clk);
        chk("ovr_cnt",     ocnt - o0, 1);
        chk("ovr_novalid", vcnt - v0, 0);
        chk("ovr_busy",    int'(busy_o), 1);
        @(posedge clk); #1;
        bsy = 1'b0;
        wait_cycles(4);
        @(negedge clk);
        chk("ovr_vcnt",  vcnt - v0, 1);
        chk("ovr_cap_a", cap_a, 1);
        chk("ovr_cap_p", cap_p, 4);
        chk("ovr_once",  ocnt - o0, 1);

        // Reset at pixel (4,3), then a clean frame.
        v0 = vcnt;
        send_pixels(vecs[3].pat, 28);
        @(posedge clk); #1;
        hc = 3'd4; vc = 3'd3; m = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dv = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_area", int'(area), 0);
        send_pixels(vecs[4].pat, N);
        end_frame();
        wait_cycles(4);
        @(negedge clk);
        chk("mid_vcnt",  vcnt - v0, 1);
        chk("mid_cap_a", cap_a, 6);
        chk("mid_cap_p", cap_p, 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
